// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD MM:SS timer blocks.
//   state_t      : timer FSM states (IDLE/RUN/PAUSE/DONE)
//   bcd_digit_t  : one 4-bit BCD digit
//   clamp_digit  : saturates a BCD digit to a legal maximum
package timer_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam int SEC_TENS_MAX = 5;
   localparam int BCD_ONES_MAX = 9;

   function automatic bcd_digit_t clamp_digit(input bcd_digit_t d, input int max_v);
      return (int'(d) > max_v) ? bcd_digit_t'(max_v) : d;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with synchronous load.
//   clk  : clock (rising edge)
//   rst  : synchronous active-high reset, clears q
//   en   : decrement by one this cycle (wraps 0 -> MODULUS-1)
//   load : load d into q (wins over en)
//   d    : load value
//   q    : current digit
//   bo   : borrow out, high when decrementing from 0
module bcd_digit_down #(
   parameter int MODULUS = 10,
   parameter int WIDTH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             bo
);

   localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

   assign bo = en && (q == '0);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (load)
         q <= d;
      else if (en)
         q <= (q == '0) ? TOP : q - WIDTH'(1);
   end

endmodule

// File: rtl/bcd_countdown_mmss.sv
// BCD MM:SS countdown timer. Loads a start value, decrements one second per
// tick_en while running, and flags expiry on the terminal tick.
// Fields are 7-bit BCD: [6:4] tens, [3:0] ones.
//   clk, rst          : clock, synchronous active-high reset
//   tick_en           : 1-cycle 1 Hz strobe
//   load/load_min/sec : load start value (clamped per digit), ignored in RUN
//   start, pause      : begin/resume and suspend counting
//   min, sec          : current count
//   running           : high in RUN
//   done              : 1-cycle pulse on terminal tick
//   expired           : high in DONE until load/rst
// Build option: define AUTO_RELOAD_EN to make the terminal tick reload the
// last loaded value and keep running instead of stopping in DONE.
module bcd_countdown_mmss
   import timer_pkg::*;
#(
   parameter int MIN_TENS_MAX = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_en,
   input  logic       load,
   input  logic [6:0] load_min,
   input  logic [6:0] load_sec,
   input  logic       start,
   input  logic       pause,
   output logic [6:0] min,
   output logic [6:0] sec,
   output logic       running,
   output logic       done,
   output logic       expired
);

   state_t     state;
   logic [6:0] rl_min, rl_sec;

   // clamp each incoming digit to its legal range
   bcd_digit_t mt_c, mo_c, st_c, so_c;
   assign mt_c = clamp_digit({1'b0, load_min[6:4]}, MIN_TENS_MAX);
   assign mo_c = clamp_digit(load_min[3:0], BCD_ONES_MAX);
   assign st_c = clamp_digit({1'b0, load_sec[6:4]}, SEC_TENS_MAX);
   assign so_c = clamp_digit(load_sec[3:0], BCD_ONES_MAX);

   logic [6:0] cl_min, cl_sec;
   assign cl_min = {mt_c[2:0], mo_c};
   assign cl_sec = {st_c[2:0], so_c};

   logic load_acc, dec, count_zero, terminal, ar_load, dig_load;
   assign load_acc   = load && (state != RUN);
   // pause in the same cycle as a tick stops the clock before the tick lands
   assign dec        = (state == RUN) && tick_en && !pause;
   assign count_zero = (min == 7'h00) && (sec == 7'h00);
   assign terminal   = (min == 7'h00) && (sec == 7'h01);

`ifdef AUTO_RELOAD_EN
   assign ar_load = dec && terminal;
`else
   assign ar_load = 1'b0;
`endif

   assign dig_load = load_acc || ar_load;

   logic [6:0] d_min, d_sec;
   assign d_min = load_acc ? cl_min : rl_min;
   assign d_sec = load_acc ? cl_sec : rl_sec;

   // digit chain: sec ones -> sec tens -> min ones -> min tens, linked by borrow
   logic so_bo, st_bo, mo_bo, mt_bo;

   bcd_digit_down #(.MODULUS(BCD_ONES_MAX + 1), .WIDTH(4)) u_sec_ones (
      .clk(clk), .rst(rst), .en(dec), .load(dig_load),
      .d(d_sec[3:0]), .q(sec[3:0]), .bo(so_bo));

   bcd_digit_down #(.MODULUS(SEC_TENS_MAX + 1), .WIDTH(3)) u_sec_tens (
      .clk(clk), .rst(rst), .en(so_bo), .load(dig_load),
      .d(d_sec[6:4]), .q(sec[6:4]), .bo(st_bo));

   bcd_digit_down #(.MODULUS(BCD_ONES_MAX + 1), .WIDTH(4)) u_min_ones (
      .clk(clk), .rst(rst), .en(st_bo), .load(dig_load),
      .d(d_min[3:0]), .q(min[3:0]), .bo(mo_bo));

   bcd_digit_down #(.MODULUS(MIN_TENS_MAX + 1), .WIDTH(3)) u_min_tens (
      .clk(clk), .rst(rst), .en(mo_bo), .load(dig_load),
      .d(d_min[6:4]), .q(min[6:4]), .bo(mt_bo));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         running <= 1'b0;
         done    <= 1'b0;
         expired <= 1'b0;
         rl_min  <= 7'h00;
         rl_sec  <= 7'h00;
      end else begin
         done <= 1'b0;
         if (load_acc) begin
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
            rl_min  <= cl_min;
            rl_sec  <= cl_sec;
         end else begin
            case (state)
               IDLE, PAUSE: begin
                  // in PAUSE, start beats a simultaneous pause
                  if (start && !count_zero) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end
               RUN: begin
                  if (pause) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                  // mt_bo only fires on a 00:00 underflow, which cannot be
                  // reached; treating it as terminal keeps the count from wrapping
                  end else if (dec && (terminal || mt_bo)) begin
                     done <= 1'b1;
`ifndef AUTO_RELOAD_EN
                     state   <= DONE;
                     running <= 1'b0;
                     expired <= 1'b1;
`endif
                  end
               end
               DONE: ;
               default: begin
                  state   <= IDLE;
                  running <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bcd_countdown_mmss.sv
module tb_bcd_countdown_mmss;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_en = 1'b0;
   logic       load = 1'b0;
   logic [6:0] load_min = 7'h00;
   logic [6:0] load_sec = 7'h00;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [6:0] min, sec;
   logic       running, done, expired;

   int checks = 0;
   int failures = 0;

   bcd_countdown_mmss #(.MIN_TENS_MAX(5)) dut (
      .clk(clk), .rst(rst), .tick_en(tick_en), .load(load),
      .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
      .min(min), .sec(sec), .running(running), .done(done), .expired(expired));

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // count + flags in one go
   task automatic chk_all(input string tag, input logic [6:0] em, input logic [6:0] es,
                          input logic er, input logic ed, input logic ee);
      chk({tag, ".min"}, {25'b0, min}, {25'b0, em});
      chk({tag, ".sec"}, {25'b0, sec}, {25'b0, es});
      chk({tag, ".running"}, {31'b0, running}, {31'b0, er});
      chk({tag, ".done"}, {31'b0, done}, {31'b0, ed});
      chk({tag, ".expired"}, {31'b0, expired}, {31'b0, ee});
   endtask

   task automatic do_load(input logic [6:0] m, input logic [6:0] s);
      load = 1'b1; load_min = m; load_sec = s;
      cyc();
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic do_pause();
      pause = 1'b1; cyc(); pause = 1'b0;
   endtask

   task automatic do_tick();
      tick_en = 1'b1; cyc(); tick_en = 1'b0;
   endtask

   initial begin
      cyc(); cyc();
      rst = 1'b0;
      chk_all("reset", 7'h00, 7'h00, 0, 0, 0);

`ifdef AUTO_RELOAD_EN
      // auto-reload: period equals loaded value, never expires
      do_load(7'h00, 7'h02);
      do_start();
      do_tick(); chk_all("ar.t1", 7'h00, 7'h01, 1, 0, 0);
      do_tick(); chk_all("ar.t2", 7'h00, 7'h02, 1, 1, 0);
      do_tick(); chk_all("ar.t3", 7'h00, 7'h01, 1, 0, 0);
      do_tick(); chk_all("ar.t4", 7'h00, 7'h02, 1, 1, 0);
      cyc();     chk_all("ar.idle", 7'h00, 7'h02, 1, 0, 0);
`else
      // 1: 00:03 runs out
      do_load(7'h00, 7'h03); chk_all("t1.load", 7'h00, 7'h03, 0, 0, 0);
      do_start();            chk_all("t1.start", 7'h00, 7'h03, 1, 0, 0);
      cyc();                 chk_all("t1.hold", 7'h00, 7'h03, 1, 0, 0);
      do_tick();             chk_all("t1.k1", 7'h00, 7'h02, 1, 0, 0);
      do_tick();             chk_all("t1.k2", 7'h00, 7'h01, 1, 0, 0);
      do_tick();             chk_all("t1.k3", 7'h00, 7'h00, 0, 1, 1);
      cyc();                 chk_all("t1.after", 7'h00, 7'h00, 0, 0, 1);
      do_start();            chk_all("t1.startdone", 7'h00, 7'h00, 0, 0, 1);
      do_tick();             chk_all("t1.tickdone", 7'h00, 7'h00, 0, 0, 1);

      // 2: borrow across every digit
      do_load(7'h10, 7'h00); chk_all("t2.load", 7'h10, 7'h00, 0, 0, 0);
      do_start();
      do_tick();             chk_all("t2.k1", 7'h09, 7'h59, 1, 0, 0);
      do_pause();
      do_load(7'h00, 7'h10);
      do_start();
      do_tick();             chk_all("t2.k2", 7'h00, 7'h09, 1, 0, 0);

      // 3: pause holds count; start+pause precedence
      do_pause();
      do_load(7'h00, 7'h05);
      do_start();
      do_tick();             chk_all("t3.k1", 7'h00, 7'h04, 1, 0, 0);
      do_pause();            chk_all("t3.pause", 7'h00, 7'h04, 0, 0, 0);
      do_tick(); do_tick(); do_tick();
      chk_all("t3.held", 7'h00, 7'h04, 0, 0, 0);
      start = 1'b1; pause = 1'b1; cyc(); start = 1'b0; pause = 1'b0;
      chk("t3.sp_in_pause", {31'b0, running}, 32'd1);
      start = 1'b1; pause = 1'b1; cyc(); start = 1'b0; pause = 1'b0;
      chk("t3.sp_in_run", {31'b0, running}, 32'd0);
      do_start();
      do_tick();             chk_all("t3.k2", 7'h00, 7'h03, 1, 0, 0);

      // 4: load ignored in RUN; clamping; start at zero ignored
      do_load(7'h7F, 7'h6C); chk_all("t4.loadrun", 7'h00, 7'h03, 1, 0, 0);
      do_pause();
      do_load(7'h7F, 7'h6C); chk_all("t4.clamp", 7'h59, 7'h59, 0, 0, 0);
      do_load(7'h4A, 7'h3B); chk_all("t4.clamp1", 7'h49, 7'h39, 0, 0, 0);
      do_load(7'h00, 7'h00);
      do_start();            chk_all("t4.startzero", 7'h00, 7'h00, 0, 0, 0);
      do_tick();             chk_all("t4.tickidle", 7'h00, 7'h00, 0, 0, 0);

      // 5: reset mid-run
      do_load(7'h01, 7'h00);
      do_start();
      do_tick(); do_tick();  chk_all("t5.k2", 7'h00, 7'h58, 1, 0, 0);
      rst = 1'b1; cyc(); rst = 1'b0;
      chk_all("t5.rst", 7'h00, 7'h00, 0, 0, 0);
      do_tick(); do_tick();  chk_all("t5.ticks", 7'h00, 7'h00, 0, 0, 0);
      do_start();            chk_all("t5.start", 7'h00, 7'h00, 0, 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
